// File: rtl/prng_arbiter_pkg.sv
// Shared types and constants for the PRNG arbiter: FSM states, LFSR taps,
// the default seed and the single-step LFSR function.
package prng_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2
    } state_e;

    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

    localparam int TAP0 = 0;
    localparam int TAP1 = 10;
    localparam int TAP2 = 30;
    localparam int TAP3 = 31;

    // Fibonacci step: feedback enters at the MSB, state shifts toward bit 0.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[TAP0] ^ s[TAP1] ^ s[TAP2] ^ s[TAP3], s[31:1]};
    endfunction

endpackage

// File: rtl/prng_arbiter_if.sv
// Consumer-facing bus of the PRNG arbiter: seeding, request/grant and draw data.
interface prng_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic               seed_load;
    logic [31:0]        seed_data;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic               rnd_valid;
    logic [31:0]        rnd_data;
    logic               busy;
    logic [15:0]        draw_cnt;

    modport master (
        output seed_load, seed_data, req,
        input  gnt, rnd_valid, rnd_data, busy, draw_cnt
    );

    modport slave (
        input  seed_load, seed_data, req,
        output gnt, rnd_valid, rnd_data, busy, draw_cnt
    );
endinterface

// File: rtl/prng_arbiter_lfsr_core.sv
// 32-bit Fibonacci LFSR with load and step enables; a zero load value is
// replaced by SEED so the all-zero lockup state is unreachable.
module prng_arbiter_lfsr_core
    import prng_arbiter_pkg::*;
#(
    parameter logic [31:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        step,
    output logic [31:0] state
);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEED;
        end else if (load) begin
            state <= (load_data == 32'd0) ? SEED : load_data;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/prng_arbiter.sv
// Round-robin arbiter handing out draws of one shared LFSR; each grant takes
// the current state and advances the LFSR so no two requesters see one value.
module prng_arbiter
    import prng_arbiter_pkg::*;
#(
    parameter int          NUM_REQ        = 3,
    parameter logic [31:0] SEED           = DEFAULT_SEED,
    parameter int          WARMUP         = 16,
    parameter int          STEPS_PER_DRAW = 1
) (
    input  logic         clk,
    input  logic         reset,
    prng_arbiter_if.slave bus
);

    localparam int     PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam state_e INIT_ST = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

    state_e             state, state_d;
    logic [31:0]        cnt, cnt_d;
    logic [PTR_W-1:0]   ptr, sel, ptr_next;
    logic [NUM_REQ-1:0] grant_vec;
    logic               any_req;
    logic               do_grant;
    logic               lfsr_step;
    logic [31:0]        lfsr_state;

    logic [NUM_REQ-1:0] gnt_p1;
    logic               vld_p1;
    logic [31:0]        rnd_data_p1;
    logic [15:0]        draw_cnt;

    prng_arbiter_lfsr_core #(
        .SEED (SEED)
    ) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .load      (bus.seed_load),
        .load_data (bus.seed_data),
        .step      (lfsr_step),
        .state     (lfsr_state)
    );

    // First pass searches at/after the pointer, second pass wraps to bit 0.
    always_comb begin
        any_req   = 1'b0;
        sel       = ptr;
        grant_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_req && bus.req[i] && (i >= int'(ptr))) begin
                any_req      = 1'b1;
                sel          = i[PTR_W-1:0];
                grant_vec[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_req && bus.req[i]) begin
                any_req      = 1'b1;
                sel          = i[PTR_W-1:0];
                grant_vec[i] = 1'b1;
            end
        end
        ptr_next = (sel == PTR_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        lfsr_step = 1'b0;
        do_grant  = 1'b0;
        if (bus.seed_load) begin
            state_d = INIT_ST;
            cnt_d   = 32'd0;
        end else begin
            case (state)
                ST_WARMUP: begin
                    lfsr_step = 1'b1;
                    if (cnt == 32'(WARMUP - 1)) begin
                        state_d = ST_RUN;
                        cnt_d   = 32'd0;
                    end else begin
                        cnt_d = cnt + 32'd1;
                    end
                end
                ST_RUN: begin
                    if (any_req) begin
                        do_grant  = 1'b1;
                        lfsr_step = 1'b1;
                        if (STEPS_PER_DRAW > 1) begin
                            state_d = ST_STEP;
                            cnt_d   = 32'd0;
                        end
                    end
                end
                ST_STEP: begin
                    lfsr_step = 1'b1;
                    if (cnt == 32'(STEPS_PER_DRAW - 2)) begin
                        state_d = ST_RUN;
                        cnt_d   = 32'd0;
                    end else begin
                        cnt_d = cnt + 32'd1;
                    end
                end
                default: begin
                    state_d = INIT_ST;
                    cnt_d   = 32'd0;
                end
            endcase
        end
    end

    // Grant edge: registered outputs p1 carry the draw taken from the LFSR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= INIT_ST;
            cnt         <= 32'd0;
            ptr         <= '0;
            gnt_p1      <= '0;
            vld_p1      <= 1'b0;
            rnd_data_p1 <= 32'd0;
            draw_cnt    <= 16'd0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            gnt_p1 <= do_grant ? grant_vec : '0;
            vld_p1 <= do_grant;
            if (do_grant) begin
                rnd_data_p1 <= lfsr_state;
                ptr         <= ptr_next;
                draw_cnt    <= draw_cnt + 16'd1;
            end
        end
    end

    assign bus.gnt       = gnt_p1;
    assign bus.rnd_valid = vld_p1;
    assign bus.rnd_data  = rnd_data_p1;
    assign bus.busy      = (state != ST_RUN);
    assign bus.draw_cnt  = draw_cnt;

endmodule
